mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_map_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 13 +
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Memory map constants, FSM encoding and region helper
// shared by the memory port arbiter.
package mem_map_pkg;

    localparam logic [63:0] MAP_ROM_BASE = 64'h0000;
    localparam logic [63:0] MAP_ROM_SIZE = 64'h1000;
    localparam logic [63:0] MAP_RAM_BASE = 64'h1000;
    localparam logic [63:0] MAP_RAM_SIZE = 64'h2000;

    localparam int BRAM_DEPTH = 3072;
    localparam int BRAM_AW    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Subtraction only happens once addr >= base, so it cannot wrap.
    function automatic logic in_region(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] size
    );
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a conflict the port
// not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single BRAM port
// with region checking and a 3-state access FSM.
module mem_port_arbiter
    import mem_map_pkg::*;
#(
    parameter logic [63:0] ROM_BASE = MAP_ROM_BASE,
    parameter logic [63:0] ROM_SIZE = MAP_ROM_SIZE,
    parameter logic [63:0] RAM_BASE = MAP_RAM_BASE,
    parameter logic [63:0] RAM_SIZE = MAP_RAM_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p0_req,
    input  logic [63:0]        p0_addr,
    input  logic               p0_we,
    input  logic [31:0]        p0_wdata,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,
    output logic               p0_err,
    input  logic               p1_req,
    input  logic [63:0]        p1_addr,
    input  logic               p1_we,
    input  logic [31:0]        p1_wdata,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,
    output logic               p1_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [BRAM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    state_t state, state_nx;

    logic               last;
    logic               win;
    logic [BRAM_AW-1:0] addr_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic               err_q;

    logic        arb;
    logic        pick;
    logic [63:0] pick_addr;
    logic        pick_we;
    logic [31:0] pick_wdata;
    logic        pick_err;
    logic [31:0] rd;

    rr_arbiter2 u_rr (
        .req    ({p1_req, p0_req}),
        .last   (last),
        .winner (pick)
    );

    always_comb begin
        arb        = (state != GRANT) && (p0_req || p1_req);
        pick_addr  = pick ? p1_addr  : p0_addr;
        pick_we    = pick ? p1_we    : p0_we;
        pick_wdata = pick ? p1_wdata : p0_wdata;
        if (pick_we)
            pick_err = !in_region(pick_addr, RAM_BASE, RAM_SIZE);
        else
            pick_err = !(in_region(pick_addr, ROM_BASE, ROM_SIZE) ||
                         in_region(pick_addr, RAM_BASE, RAM_SIZE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // last resets to 1 so port 0 wins the first conflict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= 1'b1;
            win     <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (arb) begin
            last    <= pick;
            win     <= pick;
            addr_q  <= pick_addr[BRAM_AW+1:2];
            we_q    <= pick_we;
            wdata_q <= pick_wdata;
            err_q   <= pick_err;
        end
    end

    always_comb begin
        state_nx  = IDLE;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        mem_en    = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = arb ? GRANT : IDLE;
            end
            GRANT: begin
                p0_gnt   = !win;
                p1_gnt   = win;
                mem_en   = !err_q;
                state_nx = RESP;
            end
            RESP: begin
                p0_rvalid = !win;
                p1_rvalid = win;
                state_nx  = arb ? GRANT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd        = (!err_q && !we_q) ? mem_rdata : 32'h0;
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        p0_rdata  = p0_rvalid ? rd : 32'h0;
        p1_rdata  = p1_rvalid ? rd : 32'h0;
        p0_err    = p0_rvalid && err_q;
        p1_err    = p1_rvalid && err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter
// with a behavioural one-cycle-latency BRAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [63:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [63:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] bram [0:3071];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_we     (p0_we),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_we     (p1_we),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                bram[mem_addr] <= mem_wdata;
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_outs"},
            {p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err,
             mem_en, mem_we}, 64'h0);
        chk({tag, "_data"},
            {p0_rdata, p1_rdata}, 64'h0);
        chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 3072; i++) bram[i] = 32'h0;
        bram[4]   = 32'hDEADBEEF;
        bram[2]   = 32'h22222222;
        mem_rdata = 32'h0;
        reset     = 1'b1;
        p0_req = 0; p0_addr = 0; p0_we = 0; p0_wdata = 0;
        p1_req = 0; p1_addr = 0; p1_we = 0; p1_wdata = 0;
        step();
        step();
        chk_quiet("reset");
        reset = 1'b0;
        step();

        // p0 read 0x10 -> word 4
        p0_req = 1; p0_addr = 64'h10; p0_we = 0;
        step();
        chk("rd_p0_gnt", {p0_gnt, p1_gnt}, 64'b10);
        chk("rd_mem_en", {mem_en, mem_we}, 64'b10);
        chk("rd_mem_addr", mem_addr, 64'h4);
        p0_req = 0;
        step();
        chk("rd_rvalid", {p0_rvalid, p0_err, p1_rvalid}, 64'b100);
        chk("rd_rdata", p0_rdata, 64'hDEADBEEF);
        step();
        chk("rd_idle", {p0_gnt, p0_rvalid}, 64'b00);

        // p1 write 0x1004 then read it back-to-back
        p1_req = 1; p1_addr = 64'h1004; p1_we = 1;
        p1_wdata = 32'hA5A5A5A5;
        step();
        chk("wr_gnt", {p0_gnt, p1_gnt}, 64'b01);
        chk("wr_mem", {mem_en, mem_we}, 64'b11);
        chk("wr_addr", mem_addr, 64'h401);
        chk("wr_wdata", mem_wdata, 64'hA5A5A5A5);
        p1_we = 0; p1_wdata = 0;
        step();
        chk("wr_resp", {p1_rvalid, p1_err}, 64'b10);
        chk("wr_rdata", p1_rdata, 64'h0);
        step();
        chk("rb_gnt", {p1_gnt, mem_en, mem_we}, 64'b110);
        chk("rb_addr", mem_addr, 64'h401);
        p1_req = 0;
        step();
        chk("rb_resp", {p1_rvalid, p1_err}, 64'b10);
        chk("rb_rdata", p1_rdata, 64'hA5A5A5A5);
        step();

        // p1 write into ROM is rejected
        p1_req = 1; p1_addr = 64'h8; p1_we = 1;
        p1_wdata = 32'h12345678;
        step();
        chk("rom_wr_gnt", {p1_gnt, mem_en, mem_we}, 64'b100);
        p1_req = 0; p1_we = 0;
        step();
        chk("rom_wr_resp", {p1_rvalid, p1_err}, 64'b11);
        chk("rom_wr_rdata", p1_rdata, 64'h0);
        chk("rom_word2", bram[2], 64'h22222222);
        step();

        // p0 out-of-map reads, incl. top of 64-bit space
        p0_req = 1; p0_addr = 64'h3000; p0_we = 0;
        step();
        chk("oob1_gnt", {p0_gnt, mem_en}, 64'b10);
        p0_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        chk("oob1_resp", {p0_rvalid, p0_err}, 64'b11);
        chk("oob1_rdata", p0_rdata, 64'h0);
        step();
        chk("oob2_gnt", {p0_gnt, mem_en}, 64'b10);
        p0_req = 0;
        step();
        chk("oob2_resp", {p0_rvalid, p0_err}, 64'b11);
        chk("oob2_rdata", p0_rdata, 64'h0);
        // last byte of RAM is in range
        p0_req = 1; p0_addr = 64'h2FFC;
        step();
        chk("ramtop_gnt", {p0_gnt, mem_en}, 64'b11);
        p0_req = 0;
        step();
        chk("ramtop_resp", {p0_rvalid, p0_err}, 64'b10);

        // both requesting from reset: p0,p1,p0,p1 every 2 cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0_req = 1; p0_addr = 64'h0;    p0_we = 0;
        p1_req = 1; p1_addr = 64'h1000; p1_we = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rr_gnt%0d", i), {p0_gnt, p1_gnt},
                {62'h0, (i % 4) == 0, (i % 4) == 2});
            chk($sformatf("rr_rv%0d", i), {p0_rvalid, p1_rvalid},
                {62'h0, (i % 4) == 1, (i % 4) == 3});
        end

        // reset while p0 is in GRANT
        step();
        chk("pre_rst_gnt", {p0_gnt, p1_gnt}, 64'b10);
        reset = 1'b1;
        step();
        chk_quiet("rst_grant");
        reset = 1'b0;
        step();
        chk("post_rst_gnt", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid},
            64'b1000);
        p0_req = 0; p1_req = 0;
        step();
        chk("post_rst_rv", {p0_rvalid, p1_rvalid}, 64'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
